// File: rtl/fpu_div_pkg.sv
// rtl/fpu_div_pkg.sv - shared types, constants and operand unpack helpers for the divider front end
package fpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BIAS_D = 1023;
  localparam int BIAS_S = 127;
  localparam int EXP_W  = 13;

  localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] QNAN_S = 32'h7FC0_0000;

  localparam int FLAG_INV = 1;
  localparam int FLAG_DZ  = 0;

  // One operand after field extraction; sig is left-aligned with the hidden bit at [52].
  typedef struct packed {
    logic                    sign;
    logic                    is_nan;
    logic                    is_inf;
    logic                    is_zero;
    logic signed [EXP_W-1:0] exp;
    logic [52:0]             sig;
  } operand_t;

  function automatic operand_t unpack_op(input logic [63:0] x, input logic dbl);
    operand_t    o;
    logic [10:0] e;
    logic [51:0] f;
    logic        e_max;
    logic        e_zero;
    int          bias;
    if (dbl) begin
      o.sign = x[63];
      e      = x[62:52];
      f      = x[51:0];
      e_max  = &x[62:52];
      bias   = BIAS_D;
    end else begin
      o.sign = x[31];
      e      = {3'd0, x[30:23]};
      f      = {x[22:0], 29'd0};
      e_max  = &x[30:23];
      bias   = BIAS_S;
    end
    e_zero    = (e == 11'd0);
    o.is_nan  = e_max && (f != 52'd0);
    o.is_inf  = e_max && (f == 52'd0);
    o.is_zero = e_zero && (f == 52'd0);
    o.sig     = {~e_zero, f};
    // Denormals share the exponent of the smallest normal; the hidden bit is 0.
    o.exp     = EXP_W'(e_zero ? (1 - bias) : (int'(e) - bias));
    return o;
  endfunction

  function automatic logic [63:0] qnan_res(input logic dbl);
    return dbl ? QNAN_D : {32'd0, QNAN_S};
  endfunction

  function automatic logic [63:0] inf_res(input logic dbl, input logic s);
    return dbl ? {s, 11'h7FF, 52'd0} : {32'd0, s, 8'hFF, 23'd0};
  endfunction

  function automatic logic [63:0] zero_res(input logic dbl, input logic s);
    return dbl ? {s, 63'd0} : {32'd0, s, 31'd0};
  endfunction

endpackage

// File: rtl/div_operand_prep_if.sv
// rtl/div_operand_prep_if.sv - operand input and prepared-significand output handshake bundle
interface div_operand_prep_if;
  import fpu_div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [63:0]      a;
  logic [63:0]      b;
  logic             db;
  logic             out_valid;
  logic             out_ready;
  logic [52:0]      fa;
  logic [52:0]      fb;
  logic             db_out;
  logic [EXP_W-1:0] eq;
  logic             sq;
  logic             special;
  logic [63:0]      special_res;
  logic [1:0]       flags;

  modport master (
    output in_valid, a, b, db, out_ready,
    input  in_ready, out_valid, fa, fb, db_out, eq, sq, special, special_res, flags
  );

  modport slave (
    input  in_valid, a, b, db, out_ready,
    output in_ready, out_valid, fa, fb, db_out, eq, sq, special, special_res, flags
  );

endinterface

// File: rtl/lzc_step.sv
// rtl/lzc_step.sv - 53-bit leading-zero count saturated at SHIFT_STEP
module lzc_step #(
  parameter int SHIFT_STEP = 8,
  localparam int CNT_W = $clog2(SHIFT_STEP + 1)
) (
  input  logic [52:0]      sig_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Walk from the LSB end upward so the final hit is the leading one; clamp at the step.
  always_comb begin
    cnt_o = CNT_W'(SHIFT_STEP);
    for (int i = 52; i >= 0; i--) begin
      if (sig_i[52 - i] && (i < SHIFT_STEP)) begin
        cnt_o = CNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/div_operand_prep.sv
// rtl/div_operand_prep.sv - unpack, normalize and special-case resolve operands for the NR divider
module div_operand_prep
  import fpu_div_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  div_operand_prep_if.slave bus
);

  localparam int CNT_W = $clog2(SHIFT_STEP + 1);

  state_t                  state_q, state_d;
  logic [52:0]             sig_a_q, sig_a_d;
  logic [52:0]             sig_b_q, sig_b_d;
  logic signed [EXP_W-1:0] ea_q, ea_d;
  logic signed [EXP_W-1:0] eb_q, eb_d;
  logic [EXP_W-1:0]        eq_q, eq_d;
  logic                    sq_q, sq_d;
  logic                    db_q, db_d;
  logic                    special_q, special_d;
  logic [63:0]             res_q, res_d;
  logic [1:0]              flags_q, flags_d;

  operand_t                ua, ub;
  logic                    spec;
  logic [63:0]             spec_res;
  logic [1:0]              spec_flags;
  logic                    q_sign;

  logic [CNT_W-1:0]        sh_a, sh_b;
  logic [52:0]             nsig_a, nsig_b;
  logic signed [EXP_W-1:0] nea, neb;

  lzc_step #(.SHIFT_STEP(SHIFT_STEP)) u_lzc_a (.sig_i(sig_a_q), .cnt_o(sh_a));
  lzc_step #(.SHIFT_STEP(SHIFT_STEP)) u_lzc_b (.sig_i(sig_b_q), .cnt_o(sh_b));

  // Decode the presented operands and resolve the special result by precedence.
  always_comb begin
    ua         = unpack_op(bus.a, bus.db);
    ub         = unpack_op(bus.b, bus.db);
    q_sign     = ua.sign ^ ub.sign;
    spec       = 1'b1;
    spec_res   = 64'd0;
    spec_flags = 2'b00;
    if (ua.is_nan || ub.is_nan) begin
      spec_res = qnan_res(bus.db);
    end else if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
      spec_res             = qnan_res(bus.db);
      spec_flags[FLAG_INV] = 1'b1;
    end else if (ub.is_zero && !ua.is_inf) begin
      spec_res            = inf_res(bus.db, q_sign);
      spec_flags[FLAG_DZ] = 1'b1;
    end else if (ua.is_inf) begin
      spec_res = inf_res(bus.db, q_sign);
    end else if (ub.is_inf || ua.is_zero) begin
      spec_res = zero_res(bus.db, q_sign);
    end else begin
      spec = 1'b0;
    end
  end

  // One normalization step; an already normalized operand sees a zero shift.
  always_comb begin
    nsig_a = sig_a_q << sh_a;
    nsig_b = sig_b_q << sh_b;
    nea    = ea_q - EXP_W'(sh_a);
    neb    = eb_q - EXP_W'(sh_b);
  end

  // Next-state and datapath update for IDLE / NORM / HOLD.
  always_comb begin
    state_d   = state_q;
    sig_a_d   = sig_a_q;
    sig_b_d   = sig_b_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    eq_d      = eq_q;
    sq_d      = sq_q;
    db_d      = db_q;
    special_d = special_q;
    res_d     = res_q;
    flags_d   = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          db_d      = bus.db;
          sq_d      = q_sign;
          special_d = spec;
          res_d     = spec_res;
          flags_d   = spec_flags;
          if (spec) begin
            sig_a_d = 53'd0;
            sig_b_d = 53'd0;
            ea_d    = '0;
            eb_d    = '0;
            eq_d    = '0;
            state_d = HOLD;
          end else begin
            sig_a_d = ua.sig;
            sig_b_d = ub.sig;
            ea_d    = ua.exp;
            eb_d    = ub.exp;
            eq_d    = ua.exp - ub.exp;
            state_d = (ua.sig[52] && ub.sig[52]) ? HOLD : NORM;
          end
        end
      end
      NORM: begin
        sig_a_d = nsig_a;
        sig_b_d = nsig_b;
        ea_d    = nea;
        eb_d    = neb;
        if (nsig_a[52] && nsig_b[52]) begin
          eq_d    = nea - neb;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sig_a_q   <= '0;
      sig_b_q   <= '0;
      ea_q      <= '0;
      eb_q      <= '0;
      eq_q      <= '0;
      sq_q      <= 1'b0;
      db_q      <= 1'b0;
      special_q <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      sig_a_q   <= sig_a_d;
      sig_b_q   <= sig_b_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      eq_q      <= eq_d;
      sq_q      <= sq_d;
      db_q      <= db_d;
      special_q <= special_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.fa          = sig_a_q;
  assign bus.fb          = sig_b_q;
  assign bus.db_out      = db_q;
  assign bus.eq          = eq_q;
  assign bus.sq          = sq_q;
  assign bus.special     = special_q;
  assign bus.special_res = res_q;
  assign bus.flags       = flags_q;

endmodule

// File: tb/tb_div_operand_prep.sv
// tb/tb_div_operand_prep.sv - randomized and directed self-checking bench for div_operand_prep
module tb_div_operand_prep;

  localparam int STEP = 8;
  localparam int C_ZERO = 0, C_DEN = 1, C_NORM = 2, C_INF = 3, C_NAN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_operand_prep_if bus ();

  div_operand_prep #(.SHIFT_STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [52:0] fa;
    logic [52:0] fb;
    logic [12:0] eq;
    logic        sq;
    logic        special;
    logic [63:0] res;
    logic [1:0]  flags;
    int          k;
  } exp_t;

  task automatic expect_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int msb_of(input longint unsigned v);
    int r;
    r = -1;
    for (int i = 0; i < 64; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Classify an operand and return its unbiased exponent and integer significand (hidden at 2^52).
  task automatic decode(input logic [63:0] x, input bit d, output int cls, output bit s,
                        output int e, output longint unsigned m);
    int ef, emax, bias;
    longint unsigned f;
    if (d) begin
      s = x[63]; ef = int'(x[62:52]); f = 64'(x[51:0]); emax = 2047; bias = 1023;
    end else begin
      s = x[31]; ef = int'(x[30:23]); f = 64'(x[22:0]) << 29; emax = 255; bias = 127;
    end
    if (ef == emax) cls = (f != 0) ? C_NAN : C_INF;
    else if (ef == 0) cls = (f == 0) ? C_ZERO : C_DEN;
    else cls = C_NORM;
    m = (ef == 0) ? f : (f | (64'd1 << 52));
    e = (ef == 0) ? (1 - bias) : (ef - bias);
  endtask

  task automatic model(input logic [63:0] a, input logic [63:0] b, input bit d, output exp_t r);
    int ca, cb, ea, eb, lza, lzb, mx;
    bit sa, sb;
    longint unsigned ma, mb;
    logic [63:0] qnan, inf, zero;
    decode(a, d, ca, sa, ea, ma);
    decode(b, d, cb, sb, eb, mb);
    r.sq = sa ^ sb;
    r.fa = '0; r.fb = '0; r.eq = '0; r.res = '0; r.flags = 2'b00; r.k = 0; r.special = 1'b1;
    qnan = d ? 64'h7FF8000000000000 : 64'h000000007FC00000;
    inf  = d ? {r.sq, 63'h7FF0000000000000} : {32'd0, r.sq, 31'h7F800000};
    zero = d ? {r.sq, 63'd0} : {32'd0, r.sq, 31'd0};
    if (ca == C_NAN || cb == C_NAN) r.res = qnan;
    else if ((ca == C_ZERO && cb == C_ZERO) || (ca == C_INF && cb == C_INF)) begin
      r.res = qnan; r.flags = 2'b10;
    end else if (cb == C_ZERO && ca != C_INF) begin
      r.res = inf; r.flags = 2'b01;
    end else if (ca == C_INF) r.res = inf;
    else if (cb == C_INF || ca == C_ZERO) r.res = zero;
    else begin
      r.special = 1'b0;
      lza = 52 - msb_of(ma);
      lzb = 52 - msb_of(mb);
      r.fa = 53'(ma << lza);
      r.fb = 53'(mb << lzb);
      r.eq = 13'((ea - lza) - (eb - lzb));
      mx = (lza > lzb) ? lza : lzb;
      r.k = (mx + STEP - 1) / STEP;
    end
  endtask

  function automatic logic [63:0] gen_op(input bit d);
    int c, e;
    logic s;
    logic [51:0] f;
    logic [22:0] fs;
    logic [63:0] x;
    c  = $urandom_range(0, 9);
    s  = 1'($urandom_range(0, 1));
    f  = 52'({$urandom, $urandom});
    fs = 23'($urandom);
    x  = {$urandom, $urandom};
    if (d) begin
      case (c)
        0: begin e = 0; f = '0; end
        1: begin e = 2047; f = '0; end
        2: begin e = 2047; f = f | 52'd1; end
        3, 4: begin e = 0; f = f >> $urandom_range(0, 51); if (f == 0) f = 52'd1; end
        default: e = $urandom_range(1, 2046);
      endcase
      x = {s, 11'(e), f};
    end else begin
      case (c)
        0: begin e = 0; fs = '0; end
        1: begin e = 255; fs = '0; end
        2: begin e = 255; fs = fs | 23'd1; end
        3, 4: begin e = 0; fs = fs >> $urandom_range(0, 22); if (fs == 0) fs = 23'd1; end
        default: e = $urandom_range(1, 254);
      endcase
      x = {x[63:32], s, 8'(e), fs};
    end
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input exp_t m, input bit d);
    expect_val({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    expect_val({tag, "_fa"}, 64'(bus.fa), 64'(m.fa));
    expect_val({tag, "_fb"}, 64'(bus.fb), 64'(m.fb));
    expect_val({tag, "_eq"}, 64'(bus.eq), 64'(m.eq));
    expect_val({tag, "_sq"}, 64'(bus.sq), 64'(m.sq));
    expect_val({tag, "_special"}, 64'(bus.special), 64'(m.special));
    expect_val({tag, "_flags"}, 64'(bus.flags), 64'(m.flags));
    expect_val({tag, "_db_out"}, 64'(bus.db_out), 64'(d));
    if (m.special) expect_val({tag, "_res"}, bus.special_res, m.res);
  endtask

  task automatic accept_op(input logic [63:0] a, input logic [63:0] b, input bit d);
    expect_val("acc_in_ready", 64'(bus.in_ready), 64'd1);
    bus.a = a;
    bus.b = b;
    bus.db = d;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input exp_t m, input bit d, output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 64) begin
      step();
      cyc++;
    end
    expect_val({tag, "_latency"}, 64'(cyc), 64'(m.k));
    check_fields(tag, m, d);
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    step();
    expect_val({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    expect_val({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_txn(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input bit d, input int hold);
    exp_t m;
    int cyc;
    model(a, b, d, m);
    bus.out_ready = (hold == 0);
    accept_op(a, b, d);
    expect_out(tag, m, d, cyc);
    for (int i = 0; i < hold; i++) begin
      step();
      check_fields({tag, "_hold"}, m, d);
    end
    release_out(tag);
  endtask

  task automatic check_zeroed(input string tag);
    expect_val({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    expect_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    expect_val({tag, "_fa"}, 64'(bus.fa), 64'd0);
    expect_val({tag, "_fb"}, 64'(bus.fb), 64'd0);
    expect_val({tag, "_eq"}, 64'(bus.eq), 64'd0);
    expect_val({tag, "_flags"}, 64'(bus.flags), 64'd0);
    expect_val({tag, "_res"}, bus.special_res, 64'd0);
    expect_val({tag, "_special"}, 64'(bus.special), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m, m2;
    int   cyc;
    bit   d;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.db        = 1'b0;
    repeat (3) step();
    check_zeroed("reset");
    rst = 1'b0;

    // 3.0 / 1.0 double
    model(64'h4008000000000000, 64'h3FF0000000000000, 1'b1, m);
    accept_op(64'h4008000000000000, 64'h3FF0000000000000, 1'b1);
    expect_out("d3_1", m, 1'b1, cyc);
    expect_val("d3_1_fa_lit", 64'(bus.fa), 64'h18000000000000);
    expect_val("d3_1_fb_lit", 64'(bus.fb), 64'h10000000000000);
    expect_val("d3_1_eq_lit", 64'(bus.eq), 64'd1);
    expect_val("d3_1_lat_lit", 64'(cyc), 64'd0);
    release_out("d3_1");

    // 3.0 / -1.0 single with garbage upper halves
    model(64'hDEADBEEF40400000, 64'h12345678BF800000, 1'b0, m);
    accept_op(64'hDEADBEEF40400000, 64'h12345678BF800000, 1'b0);
    expect_out("s3_m1", m, 1'b0, cyc);
    expect_val("s3_m1_fa_lit", 64'(bus.fa), 64'h18000000000000);
    expect_val("s3_m1_sq_lit", 64'(bus.sq), 64'd1);
    expect_val("s3_m1_db_lit", 64'(bus.db_out), 64'd0);
    release_out("s3_m1");

    // smallest double denormal / 1.0: worst-case normalization
    model(64'h0000000000000001, 64'h3FF0000000000000, 1'b1, m);
    accept_op(64'h0000000000000001, 64'h3FF0000000000000, 1'b1);
    expect_out("dmin", m, 1'b1, cyc);
    expect_val("dmin_lat_lit", 64'(cyc), 64'd7);
    expect_val("dmin_fa_lit", 64'(bus.fa), 64'h10000000000000);
    expect_val("dmin_eq_lit", 64'(bus.eq), 64'h1BCE);
    release_out("dmin");

    // 0/0 and 1.0/+0
    model(64'd0, 64'd0, 1'b1, m);
    accept_op(64'd0, 64'd0, 1'b1);
    expect_out("d0_0", m, 1'b1, cyc);
    expect_val("d0_0_res_lit", bus.special_res, 64'h7FF8000000000000);
    expect_val("d0_0_flags_lit", 64'(bus.flags), 64'd2);
    release_out("d0_0");
    model(64'h3FF0000000000000, 64'd0, 1'b1, m);
    accept_op(64'h3FF0000000000000, 64'd0, 1'b1);
    expect_out("d1_0", m, 1'b1, cyc);
    expect_val("d1_0_res_lit", bus.special_res, 64'h7FF0000000000000);
    expect_val("d1_0_flags_lit", 64'(bus.flags), 64'd1);
    release_out("d1_0");

    // backpressure with a pending transaction presented during HOLD
    model(64'h4008000000000000, 64'h3FF0000000000000, 1'b1, m);
    model(64'h000000003FC00000, 64'h00000000C0000000, 1'b0, m2);
    bus.out_ready = 1'b0;
    accept_op(64'h4008000000000000, 64'h3FF0000000000000, 1'b1);
    expect_out("bp1", m, 1'b1, cyc);
    bus.a = 64'h000000003FC00000;
    bus.b = 64'h00000000C0000000;
    bus.db = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_fields("bp_hold", m, 1'b1);
      expect_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    expect_val("bp_idle", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    expect_out("bp2", m2, 1'b0, cyc);
    release_out("bp2");

    // reset during NORM
    accept_op(64'h0000000000000001, 64'h3FF0000000000000, 1'b1);
    step();
    step();
    expect_val("rn_in_norm", 64'(bus.in_ready), 64'd0);
    #2 rst = 1'b1;
    #1 check_zeroed("rst_norm");
    step();
    rst = 1'b0;

    // reset during HOLD
    model(64'h4008000000000000, 64'h3FF0000000000000, 1'b1, m);
    bus.out_ready = 1'b0;
    accept_op(64'h4008000000000000, 64'h3FF0000000000000, 1'b1);
    expect_out("rh", m, 1'b1, cyc);
    #2 rst = 1'b1;
    #1 check_zeroed("rst_hold");
    step();
    rst = 1'b0;
    run_txn("post_rst", 64'h4008000000000000, 64'h3FF0000000000000, 1'b1, 0);

    // randomized operands against the reference model
    for (int t = 0; t < 150; t++) begin
      d = 1'($urandom_range(0, 1));
      run_txn("rnd", gen_op(d), gen_op(d), d,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_operand_prep.md
# div_operand_prep

Upstream preparation stage for the iterative Newton–Raphson significand divider in the FPU. It accepts two packed IEEE-754 operands (double, or single in the low 32 bits) through a valid/ready handshake. It unpacks them, normalizes denormal significands with a multi-cycle shifter, computes the signed unbiased quotient exponent and sign, and resolves special cases. It then presents 53-bit normalized significands (hidden bit at [52]) in exactly the format the divider consumes as `fa`/`fb`/`db`.

## Interface
- `SHIFT_STEP`, default 8: maximum left-shift per normalization cycle; a power of two, between 1 and 64.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `a`, `b`  in  64 each  dividend and divisor; single precision uses [31:0], and [63:32] is ignored.
- `db`  in  1  1 = double, 0 = single.
- `out_valid`  out  1  outputs valid.
- `out_ready`  in  1  downstream accepts.
- `fa`, `fb`  out  53 each  normalized significands; single occupies [52:29], with [28:0] = 0.
- `db_out`  out  1  registered `db`.
- `eq`  out  13  two's-complement unbiased quotient exponent, `ea − eb`.
- `sq`  out  1  quotient sign, `sa ^ sb`.
- `special`  out  1  result fully determined; the divider must be bypassed.
- `special_res`  out  64  packed special result; single results are zero-extended.
- `flags`  out  2  {invalid, div_by_zero}.

## Operation
- States are IDLE, NORM and HOLD; `in_ready = (state == IDLE)`.
- **IDLE:** on `in_valid`, register the unpacked fields.
  - Unbiased exponent is `exp − bias` for normal operands and `1 − bias` for denormals. Bias is 1023 for double and 127 for single.
  - Significand is `{hidden, frac}`, left-aligned to [52].
  - Next state is HOLD if the operand pair is special or both significands have bit52 = 1; otherwise NORM.
- **Special-case precedence:**
  1. Any NaN gives canonical qNaN (0x7FF8000000000000 / 0x7FC00000), flags 00.
  2. 0/0 or inf/inf gives qNaN with invalid = 1.
  3. finite nonzero/0 gives signed inf with div_by_zero = 1.
  4. inf/finite gives signed inf.
  5. finite/inf or 0/nonzero gives signed zero.
- When `special` = 1: `fa`, `fb` and `eq` are 0.
- **NORM:** each cycle, shift each operand with bit52 = 0 left by `min(lz, SHIFT_STEP)`, where `lz` is its leading-zero count at [52:0]. Subtract the shift amount from that operand's exponent. Transition to HOLD on the edge where both shifted values have bit52 = 1.
- **HOLD:** `out_valid` = 1. While `out_ready` = 0, all outputs are held stable and `in_valid` is ignored. On `out_ready` = 1, move to IDLE at that edge.
- `eq` is computed in HOLD entry from the final exponents. Range is [−1074−1023, 1023+1074], which fits in 13 bits with no saturation.

## Timing
- Reset: state = IDLE and every registered output = 0, so `out_valid` = 0, `in_ready` = 1, `flags` = 0, `special_res` = 0.
- Reset mid-NORM or mid-HOLD: the transaction is discarded and `out_valid` drops asynchronously.
- Accept edge T (`in_valid` & `in_ready`): `out_valid` is high after edge T+k, where k = NORM cycles.
  - Normal or special operands: k = 0.
  - Otherwise k = ceil(max(lz_a, lz_b)/SHIFT_STEP).
  - With the default step, worst case is k = 7 for double and k = 3 for single.
- Throughput: one transaction per (k + 1 + HOLD wait) cycles; there is no overlap.
- `db` is sampled only at accept. The `db_out`, `fa` and `fb` formats are stable throughout HOLD.

## Structure
- Package `fpu_div_pkg` holds:
  - the state enum,
  - `BIAS_D` = 1023 and `BIAS_S` = 127,
  - the canonical qNaN constants,
  - the flag bit indices,
  - `EXP_W` = 13.
- Sub-module `lzc_step`: combinational 53-bit leading-zero count saturated at `SHIFT_STEP`. It is instantiated once per operand.

## Test plan
- Double a = 0x4008000000000000 (3.0), b = 0x3FF0000000000000 (1.0) → `out_valid` after T:
  - `fa` = 0x18000000000000, `fb` = 0x10000000000000
  - `eq` = 1, `sq` = 0, `special` = 0
- Single a = 0x40400000, b = 0xBF800000 → `fa` = 0x18000000000000, `fb` = 0x10000000000000, `eq` = 1, `sq` = 1, `db_out` = 0.
- Double a = 0x0000000000000001, b = 1.0 → 7 NORM cycles, then `out_valid` after T+7:
  - `fa` = 0x10000000000000
  - `eq` = −1074 (0x1BCE)
- Double 0/0 → `special` = 1, `special_res` = 0x7FF8000000000000, `flags` = 10. Double 1.0/+0 → `special_res` = 0x7FF0000000000000, `flags` = 01. Both have k = 0.
- Backpressure: hold `out_ready` = 0 for 5 cycles with `in_valid` = 1 and new operands applied → outputs unchanged and `in_ready` = 0. Then `out_ready` = 1 → IDLE next cycle, and the pending operands are accepted there.
- Assert `rst` during NORM → `out_valid` = 0 immediately and all outputs 0. After `rst` deasserts, `in_ready` = 1 and a fresh 3.0/1.0 transaction completes correctly.
